// File: rtl/axi_stream_scoreboard.sv
// axi_stream_scoreboard
// Passive AXI4-Stream scoreboard. Expected beats are buffered in a DEPTH-entry
// FIFO and each actual beat is compared in order against the oldest one.
// Ports:
//   i_aclk            clock
//   i_areset          synchronous reset, active-high (priority over i_clear)
//   i_clear           synchronous clear of FIFO, counters and flags
//   i_exp_*           observed expected stream (tvalid/tready/tdata/tkeep/tlast/tid/tdest)
//   i_act_*           observed actual stream (same fields)
//   o_match_cnt       beats compared equal (saturating)
//   o_err_cnt         beats compared unequal (saturating)
//   o_err_pulse       one-cycle pulse per mismatching beat
//   o_first_err_idx   actual-beat index of the first mismatch
//   o_level           expected beats currently buffered
//   o_overflow        sticky: expected beat dropped on a full FIFO
//   o_underrun        sticky: actual beat with no expected beat available
module axi_stream_scoreboard #(
    parameter int unsigned WIDTH_DATA   = 64,
    parameter int unsigned WIDTH_DS     = WIDTH_DATA / 8,
    parameter int unsigned WIDTH_TID    = 8,
    parameter int unsigned WIDTH_TDEST  = 3,
    parameter int unsigned DEPTH        = 16,
    parameter bit          CMP_SIDEBAND = 1'b1
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic                    i_clear,
    input  logic                    i_exp_tvalid,
    input  logic                    i_exp_tready,
    input  logic [WIDTH_DATA-1:0]   i_exp_tdata,
    input  logic [WIDTH_DS-1:0]     i_exp_tkeep,
    input  logic                    i_exp_tlast,
    input  logic [WIDTH_TID-1:0]    i_exp_tid,
    input  logic [WIDTH_TDEST-1:0]  i_exp_tdest,
    input  logic                    i_act_tvalid,
    input  logic                    i_act_tready,
    input  logic [WIDTH_DATA-1:0]   i_act_tdata,
    input  logic [WIDTH_DS-1:0]     i_act_tkeep,
    input  logic                    i_act_tlast,
    input  logic [WIDTH_TID-1:0]    i_act_tid,
    input  logic [WIDTH_TDEST-1:0]  i_act_tdest,
    output logic [31:0]             o_match_cnt,
    output logic [31:0]             o_err_cnt,
    output logic                    o_err_pulse,
    output logic [31:0]             o_first_err_idx,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_overflow,
    output logic                    o_underrun
);

    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned LW     = PW + 1;
    localparam int unsigned BW     = WIDTH_DATA + WIDTH_DS + 1 + WIDTH_TID + WIDTH_TDEST;
    localparam int unsigned O_KEEP = WIDTH_DATA;
    localparam int unsigned O_LAST = O_KEEP + WIDTH_DS;
    localparam int unsigned O_TID  = O_LAST + 1;
    localparam int unsigned O_DEST = O_TID + WIDTH_TID;

    logic [BW-1:0]          r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic [31:0]            r_match_cnt;
    logic [31:0]            r_err_cnt;
    logic                   r_err_pulse;
    logic [31:0]            r_first_err_idx;
    logic [31:0]            r_beat_idx;
    logic                   r_overflow;
    logic                   r_underrun;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_do_write;
    logic                   w_do_read;
    logic                   w_drop;
    logic                   w_no_exp;
    logic [BW-1:0]          w_exp_beat;
    logic [BW-1:0]          w_head;
    logic [WIDTH_DATA-1:0]  w_head_data;
    logic [WIDTH_DS-1:0]    w_head_keep;
    logic                   w_head_last;
    logic [WIDTH_TID-1:0]   w_head_tid;
    logic [WIDTH_TDEST-1:0] w_head_tdest;
    logic                   w_data_diff;
    logic                   w_side_diff;
    logic                   w_mismatch;
    logic                   w_err;
    logic                   w_match;

    // Handshakes and FIFO status
    assign w_push  = i_exp_tvalid & i_exp_tready;
    assign w_pop   = i_act_tvalid & i_act_tready;
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));

    // Empty FIFO with push+pop bypasses storage; a full FIFO accepts a push only alongside a pop
    assign w_do_write = w_push & ~(w_empty & w_pop) & (~w_full | w_pop);
    assign w_do_read  = w_pop & ~w_empty;
    assign w_drop     = w_push & w_full & ~w_pop;
    assign w_no_exp   = w_pop & w_empty & ~w_push;

    assign w_exp_beat = {i_exp_tdest, i_exp_tid, i_exp_tlast, i_exp_tkeep, i_exp_tdata};
    assign w_head     = w_empty ? w_exp_beat : r_mem[r_rd_ptr];

    assign w_head_data  = w_head[WIDTH_DATA-1:0];
    assign w_head_keep  = w_head[O_KEEP +: WIDTH_DS];
    assign w_head_last  = w_head[O_LAST];
    assign w_head_tid   = w_head[O_TID +: WIDTH_TID];
    assign w_head_tdest = w_head[O_DEST +: WIDTH_TDEST];

    // Keep mismatch, or any kept byte differing
    always_comb begin
        w_data_diff = (w_head_keep != i_act_tkeep);
        for (int i = 0; i < int'(WIDTH_DS); i++) begin
            if (w_head_keep[i] && (w_head_data[8*i +: 8] != i_act_tdata[8*i +: 8])) begin
                w_data_diff = 1'b1;
            end
        end
    end

    assign w_side_diff = (w_head_last != i_act_tlast) ||
                         (w_head_tid != i_act_tid) ||
                         (w_head_tdest != i_act_tdest);

    assign w_mismatch = w_data_diff | (CMP_SIDEBAND ? w_side_diff : 1'b0);
    assign w_err      = w_pop & (w_no_exp | w_mismatch);
    assign w_match    = w_pop & ~w_no_exp & ~w_mismatch;

    // Expected-beat storage; pointers alone define validity so no reset needed
    always_ff @(posedge i_aclk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr] <= w_exp_beat;
        end
    end

    // FIFO pointers, counters and flags
    always_ff @(posedge i_aclk) begin
        if (i_areset || i_clear) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_level         <= '0;
            r_match_cnt     <= '0;
            r_err_cnt       <= '0;
            r_err_pulse     <= 1'b0;
            r_first_err_idx <= '0;
            r_beat_idx      <= '0;
            r_overflow      <= 1'b0;
            r_underrun      <= 1'b0;
        end else begin
            r_err_pulse <= w_err;

            if (w_do_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_read) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case ({w_do_write, w_do_read})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_pop) begin
                r_beat_idx <= r_beat_idx + 32'd1;
            end

            if (w_match && (r_match_cnt != 32'hFFFF_FFFF)) begin
                r_match_cnt <= r_match_cnt + 32'd1;
            end

            // Error count is saturating, so zero means no error seen since reset/clear
            if (w_err) begin
                if (r_err_cnt == '0) begin
                    r_first_err_idx <= r_beat_idx;
                end
                if (r_err_cnt != 32'hFFFF_FFFF) begin
                    r_err_cnt <= r_err_cnt + 32'd1;
                end
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_no_exp) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign o_match_cnt     = r_match_cnt;
    assign o_err_cnt       = r_err_cnt;
    assign o_err_pulse     = r_err_pulse;
    assign o_first_err_idx = r_first_err_idx;
    assign o_level         = r_level;
    assign o_overflow      = r_overflow;
    assign o_underrun      = r_underrun;

endmodule

// File: tb/tb_axi_stream_scoreboard.sv
// Testbench for axi_stream_scoreboard: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
// A second instance with sideband comparison disabled shares all stimulus.
module tb_axi_stream_scoreboard;

    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  tid;
        logic [2:0]  tdest;
    } beat_t;

    typedef struct {
        bit          ev;
        bit          av;
        bit          clr;
        logic [63:0] ed;
        logic [63:0] ad;
        logic [7:0]  ek;
        logic [7:0]  ak;
        logic [7:0]  atid;
        int          mc;
        int          ec;
        int          lvl;
        int          fe;
        bit          pulse;
        bit          ovf;
        bit          udr;
        int          nmc;
        int          nec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        exp_v = 1'b0;
    logic        exp_r = 1'b0;
    logic        act_v = 1'b0;
    logic        act_r = 1'b0;
    beat_t       exp_b = '0;
    beat_t       act_b = '0;

    logic [31:0] mc0, ec0, fe0, mc1, ec1, fe1;
    logic        pulse0, ovf0, udr0, pulse1, ovf1, udr1;
    logic [4:0]  lvl0, lvl1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    beat_t       mq[$];
    logic [31:0] m_mc [2];
    logic [31:0] m_ec [2];
    logic [31:0] m_fe [2];
    bit          m_pulse [2];
    logic [31:0] m_idx;
    bit          m_ovf;
    bit          m_udr;

    vec_t tbl[$];

    always #5 clk = ~clk;

    axi_stream_scoreboard #(.DEPTH(DEPTH), .CMP_SIDEBAND(1'b1)) dut (
        .i_aclk(clk), .i_areset(rst), .i_clear(clr),
        .i_exp_tvalid(exp_v), .i_exp_tready(exp_r), .i_exp_tdata(exp_b.data),
        .i_exp_tkeep(exp_b.keep), .i_exp_tlast(exp_b.last), .i_exp_tid(exp_b.tid),
        .i_exp_tdest(exp_b.tdest),
        .i_act_tvalid(act_v), .i_act_tready(act_r), .i_act_tdata(act_b.data),
        .i_act_tkeep(act_b.keep), .i_act_tlast(act_b.last), .i_act_tid(act_b.tid),
        .i_act_tdest(act_b.tdest),
        .o_match_cnt(mc0), .o_err_cnt(ec0), .o_err_pulse(pulse0),
        .o_first_err_idx(fe0), .o_level(lvl0), .o_overflow(ovf0), .o_underrun(udr0)
    );

    axi_stream_scoreboard #(.DEPTH(DEPTH), .CMP_SIDEBAND(1'b0)) dut_ns (
        .i_aclk(clk), .i_areset(rst), .i_clear(clr),
        .i_exp_tvalid(exp_v), .i_exp_tready(exp_r), .i_exp_tdata(exp_b.data),
        .i_exp_tkeep(exp_b.keep), .i_exp_tlast(exp_b.last), .i_exp_tid(exp_b.tid),
        .i_exp_tdest(exp_b.tdest),
        .i_act_tvalid(act_v), .i_act_tready(act_r), .i_act_tdata(act_b.data),
        .i_act_tkeep(act_b.keep), .i_act_tlast(act_b.last), .i_act_tid(act_b.tid),
        .i_act_tdest(act_b.tdest),
        .o_match_cnt(mc1), .o_err_cnt(ec1), .o_err_pulse(pulse1),
        .o_first_err_idx(fe1), .o_level(lvl1), .o_overflow(ovf1), .o_underrun(udr1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit beats_differ(input beat_t e, input beat_t a, input bit sb);
        logic [63:0] mask;
        for (int i = 0; i < 8; i++) mask[8*i +: 8] = {8{e.keep[i]}};
        if (e.keep != a.keep) return 1'b1;
        if (((e.data ^ a.data) & mask) != 64'd0) return 1'b1;
        if (sb && ((e.last != a.last) || (e.tid != a.tid) || (e.tdest != a.tdest))) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the scoreboard rules, expressed on a queue
    task automatic model_update();
        beat_t e;
        bit    have;
        bit    used;
        if (rst || clr) begin
            mq.delete();
            for (int k = 0; k < 2; k++) begin
                m_mc[k] = '0; m_ec[k] = '0; m_fe[k] = '0; m_pulse[k] = 1'b0;
            end
            m_idx = '0; m_ovf = 1'b0; m_udr = 1'b0;
            return;
        end
        used = 1'b0;
        for (int k = 0; k < 2; k++) m_pulse[k] = 1'b0;
        if (act_v && act_r) begin
            have = 1'b1;
            e    = '0;
            if (mq.size() > 0) e = mq.pop_front();
            else if (exp_v && exp_r) begin e = exp_b; used = 1'b1; end
            else begin have = 1'b0; m_udr = 1'b1; end
            for (int k = 0; k < 2; k++) begin
                if (!have || beats_differ(e, act_b, k == 0)) begin
                    if (m_ec[k] == 32'd0) m_fe[k] = m_idx;
                    if (m_ec[k] != 32'hFFFF_FFFF) m_ec[k] = m_ec[k] + 32'd1;
                    m_pulse[k] = 1'b1;
                end else if (m_mc[k] != 32'hFFFF_FFFF) begin
                    m_mc[k] = m_mc[k] + 32'd1;
                end
            end
            m_idx = m_idx + 32'd1;
        end
        if (exp_v && exp_r && !used) begin
            if (mq.size() < DEPTH) mq.push_back(exp_b);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        exp_v = 1'b0; act_v = 1'b0; exp_r = 1'b1; act_r = 1'b1; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic do_clear();
        idle(); clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic addv(input bit ev, input bit av, input bit c, input logic [63:0] ed,
                        input logic [63:0] ad, input logic [7:0] ek, input logic [7:0] ak,
                        input logic [7:0] atid, input int mc, input int ec, input int lvl,
                        input int fe, input bit pulse, input bit ovf, input bit udr,
                        input int nmc, input int nec);
        vec_t v;
        v.ev = ev; v.av = av; v.clr = c; v.ed = ed; v.ad = ad; v.ek = ek; v.ak = ak;
        v.atid = atid; v.mc = mc; v.ec = ec; v.lvl = lvl; v.fe = fe; v.pulse = pulse;
        v.ovf = ovf; v.udr = udr; v.nmc = nmc; v.nec = nec;
        tbl.push_back(v);
    endtask

    initial begin
        beat_t ref_b;
        int    ph;

        // Directed table, starting from reset state
        for (int i = 0; i < 8; i++)
            addv(1, 0, 0, 64'(i), 0, 8'hFF, 8'hFF, 0, 0, 0, i + 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            addv(0, 1, 0, 0, 64'(i), 8'hFF, 8'hFF, 0, i + 1, 0, 7 - i, 0, 0, 0, 0, i + 1, 0);
        addv(1, 1, 0, 64'h1111_2222_3333_4444, 64'hFFFF_FFFF_3333_4444, 8'h0F, 8'h0F, 0,
             9, 0, 0, 0, 0, 0, 0, 9, 0);
        addv(1, 1, 0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 8'h0F, 8'h1F, 0,
             9, 1, 0, 9, 1, 0, 0, 9, 1);
        addv(0, 1, 0, 0, 64'd5, 8'hFF, 8'hFF, 0, 9, 2, 0, 9, 1, 0, 1, 9, 2);
        addv(1, 1, 0, 64'd7, 64'd7, 8'hFF, 8'hFF, 0, 10, 2, 0, 9, 0, 0, 1, 10, 2);
        for (int i = 0; i < 5; i++)
            addv(1, 0, 0, 64'(20 + i), 0, 8'hFF, 8'hFF, 0, 10, 2, i + 1, 9, 0, 0, 1, 10, 2);
        addv(0, 0, 1, 0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addv(1, 1, 0, 64'hABCD, 64'hABCD, 8'hFF, 8'hFF, 8'h01, 0, 1, 0, 0, 1, 0, 0, 1, 0);

        // Reset state
        idle(); rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_match", mc0, 32'd0);
        chk("rst_err", ec0, 32'd0);
        chk("rst_level", 32'(lvl0), 32'd0);
        chk("rst_flags", {29'd0, pulse0, ovf0, udr0}, 32'd0);
        chk("rst_first", fe0, 32'd0);

        foreach (tbl[i]) begin
            idle();
            exp_v = tbl[i].ev; act_v = tbl[i].av; clr = tbl[i].clr;
            exp_b = '0; act_b = '0;
            exp_b.data = tbl[i].ed; exp_b.keep = tbl[i].ek;
            act_b.data = tbl[i].ad; act_b.keep = tbl[i].ak; act_b.tid = tbl[i].atid;
            tick();
            chk($sformatf("tbl%0d_match", i), mc0, 32'(tbl[i].mc));
            chk($sformatf("tbl%0d_err", i), ec0, 32'(tbl[i].ec));
            chk($sformatf("tbl%0d_level", i), 32'(lvl0), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_first", i), fe0, 32'(tbl[i].fe));
            chk($sformatf("tbl%0d_pulse", i), 32'(pulse0), 32'(tbl[i].pulse));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf0), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_udr", i), 32'(udr0), 32'(tbl[i].udr));
            chk($sformatf("tbl%0d_ns_match", i), mc1, 32'(tbl[i].nmc));
            chk($sformatf("tbl%0d_ns_err", i), ec1, 32'(tbl[i].nec));
        end

        // Single-bit error on actual beat 3
        do_clear();
        exp_b = '0; act_b = '0; exp_b.keep = 8'hFF; act_b.keep = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            idle(); exp_v = 1'b1; exp_b.data = 64'(i); tick();
        end
        for (int i = 0; i < 8; i++) begin
            idle(); act_v = 1'b1; act_b.data = 64'(i) ^ ((i == 3) ? 64'd1 : 64'd0); tick();
            chk($sformatf("flip_pulse%0d", i), 32'(pulse0), (i == 3) ? 32'd1 : 32'd0);
        end
        idle(); tick();
        chk("flip_err", ec0, 32'd1);
        chk("flip_first", fe0, 32'd3);
        chk("flip_match", mc0, 32'd7);
        chk("flip_pulse_idle", 32'(pulse0), 32'd0);

        // Overflow, then full FIFO with simultaneous push and pop
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); exp_v = 1'b1; exp_b.data = 64'(100 + i); tick();
        end
        chk("full_ovf_clear", 32'(ovf0), 32'd0);
        chk("full_level", 32'(lvl0), 32'(DEPTH));
        idle(); exp_v = 1'b1; exp_b.data = 64'(100 + DEPTH); tick();
        chk("ovf_set", 32'(ovf0), 32'd1);
        chk("ovf_level", 32'(lvl0), 32'(DEPTH));
        idle(); exp_v = 1'b1; exp_b.data = 64'd200; act_v = 1'b1; act_b.data = 64'd100; tick();
        chk("full_pp_level", 32'(lvl0), 32'(DEPTH));
        chk("full_pp_match", mc0, 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            idle(); act_v = 1'b1; act_b.data = (i == DEPTH) ? 64'd200 : 64'(100 + i); tick();
        end
        chk("drain_match", mc0, 32'(DEPTH + 1));
        chk("drain_err", ec0, 32'd0);
        chk("drain_level", 32'(lvl0), 32'd0);

        // Randomized traffic against the reference model
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            idle();
            ph = (c / 300) % 3;
            exp_v = ($urandom_range(0, 99) < ((ph == 0) ? 90 : (ph == 1) ? 30 : 60));
            act_v = ($urandom_range(0, 99) < ((ph == 0) ? 30 : (ph == 1) ? 90 : 60));
            exp_r = ($urandom_range(0, 9) != 0);
            act_r = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 299) == 0);
            rst   = ($urandom_range(0, 999) == 0);
            exp_b.data  = {$urandom, $urandom};
            exp_b.keep  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            exp_b.last  = 1'($urandom);
            exp_b.tid   = 8'($urandom);
            exp_b.tdest = 3'($urandom);
            ref_b = (mq.size() > 0) ? mq[0] : exp_b;
            act_b = ref_b;
            case ($urandom_range(0, 11))
                0: act_b.data[$urandom_range(0, 63)] = ~act_b.data[$urandom_range(0, 63)];
                1: act_b.keep = act_b.keep ^ 8'($urandom_range(1, 255));
                2: act_b.tid = act_b.tid ^ 8'h01;
                3: act_b.last = ~act_b.last;
                4: act_b.tdest = act_b.tdest ^ 3'd4;
                default: ;
            endcase
            tick();
            chk("rnd_match", mc0, m_mc[0]);
            chk("rnd_err", ec0, m_ec[0]);
            chk("rnd_pulse", 32'(pulse0), 32'(m_pulse[0]));
            chk("rnd_first", (m_ec[0] != 0) ? fe0 : 32'd0, m_fe[0]);
            chk("rnd_level", 32'(lvl0), 32'(mq.size()));
            chk("rnd_ovf", 32'(ovf0), 32'(m_ovf));
            chk("rnd_udr", 32'(udr0), 32'(m_udr));
            chk("rnd_ns_match", mc1, m_mc[1]);
            chk("rnd_ns_err", ec1, m_ec[1]);
            chk("rnd_ns_pulse", 32'(pulse1), 32'(m_pulse[1]));
            chk("rnd_ns_first", (m_ec[1] != 0) ? fe1 : 32'd0, m_fe[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
